button_event_decoder: RTL and testbench
=======================================

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter TICK_DIV, default 50000: clocks per 1 ms time-base tick (50 MHz).
REQ-002 Parameter LONG_MS, default 800: hold time, in ticks, that qualifies a long press.
REQ-003 Parameter DBL_MS, default 250: maximum release gap, in ticks, for a double click.
REQ-004 Parameter REP_MS, default 100: auto-repeat period, in ticks, while long-held.
REQ-005 ButtonEvent_CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-006 ButtonEvent_Reset_InLow  in  1  reset, asynchronous assert, active-low.
REQ-007 ButtonEvent_Button_In  in  1  debounced, clock-synchronous button level; 1 = pressed.
REQ-008 ButtonEvent_Enable  in  1  1 = decode; 0 = FSM held in IDLE, all pulses suppressed.
REQ-009 ButtonEvent_Press_Pulse  out  1  one-cycle pulse on press edge.
REQ-010 ButtonEvent_Release_Pulse  out  1  one-cycle pulse on release from an active press state.
REQ-011 ButtonEvent_Short_Pulse  out  1  one-cycle pulse: single short click confirmed.
REQ-012 ButtonEvent_Double_Pulse  out  1  one-cycle pulse: double click detected.
REQ-013 ButtonEvent_Long_Pulse  out  1  one-cycle pulse: long-press threshold reached.
REQ-014 ButtonEvent_Repeat_Pulse  out  1  one-cycle pulse every REP_MS while long-held.
REQ-015 ButtonEvent_Held  out  1  level: 1 while FSM in LONG.

Function
REQ-016 prev register samples Button_In every cycle; rise = Button_In & ~prev, fall = ~Button_In & prev.
REQ-017 All outputs registered; each pulse asserts exactly one cycle, in the cycle following the qualifying edge or tick.
REQ-018 Prescaler counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1; ms counter increments on tick, saturates at all-ones; both cleared on every FSM transition.
REQ-019 Counter widths sized by $clog2 of the largest of TICK_DIV, LONG_MS, DBL_MS, REP_MS, plus 1.
REQ-020 States: IDLE, PRESS1, WAIT2, PRESS2, LONG.
REQ-021 IDLE: rise -> PRESS1, Press_Pulse.
REQ-022 PRESS1: fall -> WAIT2, Release_Pulse; ms counter reaching LONG_MS while pressed -> LONG, Long_Pulse.
REQ-023 WAIT2: rise -> PRESS2, Press_Pulse, Double_Pulse; ms counter reaching DBL_MS -> IDLE, Short_Pulse.
REQ-024 PRESS2: fall -> IDLE, Release_Pulse; no long detection in PRESS2.
REQ-025 LONG: Repeat_Pulse each time ms counter reaches REP_MS (counter then restarts at 0); fall -> IDLE, Release_Pulse.
REQ-026 Simultaneous fall and LONG_MS threshold in PRESS1: fall wins (WAIT2, no Long_Pulse).
REQ-027 Simultaneous rise and DBL_MS threshold in WAIT2: rise wins (Double_Pulse, no Short_Pulse).
REQ-028 Enable=0: next state IDLE, counters cleared, all pulses and Held 0; prev keeps sampling.
REQ-029 Enable rising while button held: no Press_Pulse until a fresh rise.
REQ-030 Fall in IDLE produces no output.

Reset
REQ-031 Reset low: asynchronously state=IDLE, prescaler=0, ms counter=0, all outputs 0.
REQ-032 prev resets to 1, so a button held through reset produces no Press_Pulse on reset release.
REQ-033 Reset deassertion takes effect at the first rising clock edge after release; reset mid-sequence discards any pending Short/Double/Long decision.

Verification (TICK_DIV=4, LONG_MS=10, DBL_MS=5, REP_MS=3)
REQ-034 Assert reset, button 0 -> all outputs 0, state IDLE; release reset, idle 100 clk -> no pulses.
REQ-035 Press 12 clk, release -> Press_Pulse, Release_Pulse, then Short_Pulse 20 clk after the WAIT2 entry; no Double, no Long.
REQ-036 Press 8 clk, release 8 clk, press 8 clk, release -> Press x2, Double_Pulse once with the second press, Release x2; no Short_Pulse.
REQ-037 Hold 80 clk -> Long_Pulse 40 clk after PRESS1 entry, Held=1, Repeat_Pulse at +12, +24, +36 clk after LONG entry; release -> Release_Pulse, Held=0.
REQ-038 Release on exactly the cycle ms counter hits LONG_MS -> no Long_Pulse; Short_Pulse 20 clk later. Re-press on the exact DBL_MS cycle -> Double_Pulse, no Short_Pulse.
REQ-039 Reset asserted mid-LONG with button held, then released -> outputs 0 immediately, no Press_Pulse afterwards; a subsequent release and press yields a normal Press_Pulse.

Source files
------------

// File: rtl/button_event_if.sv
// Button event decoder signal bundle: button level and enable in, event pulses and held level out.
interface button_event_if;
    logic ButtonEvent_Button_In;
    logic ButtonEvent_Enable;
    logic ButtonEvent_Press_Pulse;
    logic ButtonEvent_Release_Pulse;
    logic ButtonEvent_Short_Pulse;
    logic ButtonEvent_Double_Pulse;
    logic ButtonEvent_Long_Pulse;
    logic ButtonEvent_Repeat_Pulse;
    logic ButtonEvent_Held;

    modport master (
        output ButtonEvent_Button_In,
        output ButtonEvent_Enable,
        input  ButtonEvent_Press_Pulse,
        input  ButtonEvent_Release_Pulse,
        input  ButtonEvent_Short_Pulse,
        input  ButtonEvent_Double_Pulse,
        input  ButtonEvent_Long_Pulse,
        input  ButtonEvent_Repeat_Pulse,
        input  ButtonEvent_Held
    );

    modport slave (
        input  ButtonEvent_Button_In,
        input  ButtonEvent_Enable,
        output ButtonEvent_Press_Pulse,
        output ButtonEvent_Release_Pulse,
        output ButtonEvent_Short_Pulse,
        output ButtonEvent_Double_Pulse,
        output ButtonEvent_Long_Pulse,
        output ButtonEvent_Repeat_Pulse,
        output ButtonEvent_Held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release/short/double/long/repeat events
// using a millisecond time base derived from the system clock.
module button_event_decoder #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned LONG_MS  = 800,
    parameter int unsigned DBL_MS   = 250,
    parameter int unsigned REP_MS   = 100
) (
    input logic           ButtonEvent_CLOCK_50,
    input logic           ButtonEvent_Reset_InLow,
    button_event_if.slave evt
);

    localparam int unsigned MaxA   = (TICK_DIV > LONG_MS) ? TICK_DIV : LONG_MS;
    localparam int unsigned MaxB   = (DBL_MS > REP_MS) ? DBL_MS : REP_MS;
    localparam int unsigned MaxAll = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CW     = $clog2(MaxAll) + 1;

    // Thresholds fire on the tick that moves the ms counter onto the limit.
    localparam logic [CW-1:0] TickLast = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LongLast = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] DblLast  = CW'(DBL_MS - 1);
    localparam logic [CW-1:0] RepLast  = CW'(REP_MS - 1);

    typedef enum logic [2:0] {StIdle, StPress1, StWait2, StPress2, StLong} state_e;

    state_e        state_q, state_d;
    logic          prev_q;
    logic [CW-1:0] presc_q, presc_d;
    logic [CW-1:0] ms_q, ms_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          single_q, single_d;
    logic          dbl_q, dbl_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          held_q, held_d;

    logic rise, fall, tick, clr;

    assign rise = evt.ButtonEvent_Button_In & ~prev_q;
    assign fall = ~evt.ButtonEvent_Button_In & prev_q;
    assign tick = (presc_q == TickLast);

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        single_d = 1'b0;
        dbl_d    = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        if (!evt.ButtonEvent_Enable) begin
            state_d = StIdle;
            clr     = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StPress1;
                        press_d = 1'b1;
                        clr     = 1'b1;
                    end
                end
                StPress1: begin
                    if (fall) begin
                        state_d = StWait2;
                        rel_d   = 1'b1;
                        clr     = 1'b1;
                    end else if (tick && ms_q == LongLast) begin
                        state_d = StLong;
                        long_d  = 1'b1;
                        clr     = 1'b1;
                    end
                end
                StWait2: begin
                    if (rise) begin
                        state_d = StPress2;
                        press_d = 1'b1;
                        dbl_d   = 1'b1;
                        clr     = 1'b1;
                    end else if (tick && ms_q == DblLast) begin
                        state_d  = StIdle;
                        single_d = 1'b1;
                        clr      = 1'b1;
                    end
                end
                StPress2: begin
                    if (fall) begin
                        state_d = StIdle;
                        rel_d   = 1'b1;
                        clr     = 1'b1;
                    end
                end
                StLong: begin
                    if (fall) begin
                        state_d = StIdle;
                        rel_d   = 1'b1;
                        clr     = 1'b1;
                    end else if (tick && ms_q == RepLast) begin
                        rep_d = 1'b1;
                        clr   = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end
            endcase
        end

        if (clr) begin
            presc_d = '0;
            ms_d    = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            ms_d    = (tick && ms_q != '1) ? ms_q + 1'b1 : ms_q;
        end
        held_d = (state_d == StLong);
    end

    // prev resets high so a button held through reset is not seen as a fresh press.
    always_ff @(posedge ButtonEvent_CLOCK_50 or negedge ButtonEvent_Reset_InLow) begin
        if (!ButtonEvent_Reset_InLow) begin
            state_q  <= StIdle;
            prev_q   <= 1'b1;
            presc_q  <= '0;
            ms_q     <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            single_q <= 1'b0;
            dbl_q    <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= evt.ButtonEvent_Button_In;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            single_q <= single_d;
            dbl_q    <= dbl_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            held_q   <= held_d;
        end
    end

    assign evt.ButtonEvent_Press_Pulse   = press_q;
    assign evt.ButtonEvent_Release_Pulse = rel_q;
    assign evt.ButtonEvent_Short_Pulse   = single_q;
    assign evt.ButtonEvent_Double_Pulse  = dbl_q;
    assign evt.ButtonEvent_Long_Pulse    = long_q;
    assign evt.ButtonEvent_Repeat_Pulse  = rep_q;
    assign evt.ButtonEvent_Held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a short time base (4 clk/tick).
module tb_button_event_decoder;
    localparam int unsigned TD = 4, LM = 10, DM = 5, RM = 3;
    localparam int IP = 0, IR = 1, IS = 2, ID = 3, IL = 4, IRP = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    button_event_if bus ();

    button_event_decoder #(
        .TICK_DIV(TD),
        .LONG_MS (LM),
        .DBL_MS  (DM),
        .REP_MS  (RM)
    ) dut (
        .ButtonEvent_CLOCK_50   (clk),
        .ButtonEvent_Reset_InLow(rst_n),
        .evt                    (bus)
    );

    logic [5:0] pulses;
    assign pulses = {bus.ButtonEvent_Repeat_Pulse, bus.ButtonEvent_Long_Pulse,
                     bus.ButtonEvent_Double_Pulse, bus.ButtonEvent_Short_Pulse,
                     bus.ButtonEvent_Release_Pulse, bus.ButtonEvent_Press_Pulse};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int cnt[6] = '{default: 0};
    int last[6] = '{default: -1};
    int rep_t[$];

    // Event log: cycle index is the number of rising edges seen so far.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (pulses[i]) begin
                cnt[i]  <= cnt[i] + 1;
                last[i] <= cyc;
            end
        end
        if (pulses[IRP]) rep_t.push_back(cyc);
    end

    task automatic hold(input logic b, input int n);
        bus.ButtonEvent_Button_In = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int b[6];
        rst_n = 1'b0;
        bus.ButtonEvent_Button_In = 1'b0;
        bus.ButtonEvent_Enable = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({pulses, bus.ButtonEvent_Held} !== 7'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b, expected 0", {pulses, bus.ButtonEvent_Held});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b = cnt;
        hold(1'b0, 100);
        n_vec++;
        if ((cnt[IP] + cnt[IR] + cnt[IS] + cnt[ID] + cnt[IL] + cnt[IRP])
            - (b[IP] + b[IR] + b[IS] + b[ID] + b[IL] + b[IRP]) !== 0) begin
            n_err++; $display("FAIL idle_pulses: got nonzero pulse count, expected 0");
        end
        n_vec++;
        if (bus.ButtonEvent_Held !== 1'b0) begin
            n_err++; $display("FAIL idle_held: got %b, expected 0", bus.ButtonEvent_Held);
        end
    endtask

    task automatic test_short();
        int b[6];
        int c1;
        b = cnt; c1 = cyc + 1;
        hold(1'b1, 12); hold(1'b0, 40);
        n_vec++;
        if (last[IP] !== c1 || cnt[IP] - b[IP] !== 1) begin
            n_err++; $display("FAIL short_press: got t=%0d, expected t=%0d once", last[IP], c1);
        end
        n_vec++;
        if (last[IR] !== c1 + 12 || cnt[IR] - b[IR] !== 1) begin
            n_err++; $display("FAIL short_release: got t=%0d, expected t=%0d", last[IR], c1 + 12);
        end
        n_vec++;
        if (last[IS] !== c1 + 32 || cnt[IS] - b[IS] !== 1) begin
            n_err++; $display("FAIL short_pulse: got t=%0d, expected t=%0d", last[IS], c1 + 32);
        end
        n_vec++;
        if (cnt[ID] - b[ID] !== 0 || cnt[IL] - b[IL] !== 0) begin
            n_err++; $display("FAIL short_no_dbl_long: got %0d/%0d, expected 0/0",
                              cnt[ID] - b[ID], cnt[IL] - b[IL]);
        end
    endtask

    task automatic test_double();
        int b[6];
        int c1;
        b = cnt; c1 = cyc + 1;
        hold(1'b1, 8); hold(1'b0, 8); hold(1'b1, 8); hold(1'b0, 40);
        n_vec++;
        if (cnt[IP] - b[IP] !== 2 || last[IP] !== c1 + 16) begin
            n_err++; $display("FAIL dbl_press: got n=%0d t=%0d, expected n=2 t=%0d",
                              cnt[IP] - b[IP], last[IP], c1 + 16);
        end
        n_vec++;
        if (cnt[ID] - b[ID] !== 1 || last[ID] !== c1 + 16) begin
            n_err++; $display("FAIL dbl_pulse: got n=%0d t=%0d, expected n=1 t=%0d",
                              cnt[ID] - b[ID], last[ID], c1 + 16);
        end
        n_vec++;
        if (cnt[IR] - b[IR] !== 2 || last[IR] !== c1 + 24) begin
            n_err++; $display("FAIL dbl_release: got n=%0d t=%0d, expected n=2 t=%0d",
                              cnt[IR] - b[IR], last[IR], c1 + 24);
        end
        n_vec++;
        if (cnt[IS] - b[IS] !== 0 || cnt[IL] - b[IL] !== 0) begin
            n_err++; $display("FAIL dbl_no_short_long: got %0d/%0d, expected 0/0",
                              cnt[IS] - b[IS], cnt[IL] - b[IL]);
        end
    endtask

    task automatic test_long();
        int b[6];
        int c1;
        int rb;
        b = cnt; c1 = cyc + 1; rb = rep_t.size();
        hold(1'b1, 80);
        n_vec++;
        if (bus.ButtonEvent_Held !== 1'b1) begin
            n_err++; $display("FAIL long_held: got %b, expected 1", bus.ButtonEvent_Held);
        end
        hold(1'b0, 2);
        n_vec++;
        if (bus.ButtonEvent_Held !== 1'b0) begin
            n_err++; $display("FAIL long_held_clear: got %b, expected 0", bus.ButtonEvent_Held);
        end
        hold(1'b0, 40);
        n_vec++;
        if (cnt[IL] - b[IL] !== 1 || last[IL] !== c1 + 40) begin
            n_err++; $display("FAIL long_pulse: got n=%0d t=%0d, expected n=1 t=%0d",
                              cnt[IL] - b[IL], last[IL], c1 + 40);
        end
        n_vec++;
        if (rep_t.size() - rb !== 3) begin
            n_err++; $display("FAIL long_rep_cnt: got %0d, expected 3", rep_t.size() - rb);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (rep_t[rb + k] !== c1 + 52 + 12 * k) begin
                    n_err++; $display("FAIL long_rep_time%0d: got %0d, expected %0d",
                                      k, rep_t[rb + k], c1 + 52 + 12 * k);
                end
            end
        end
        n_vec++;
        if (cnt[IR] - b[IR] !== 1 || last[IR] !== c1 + 80 || cnt[IS] - b[IS] !== 0) begin
            n_err++; $display("FAIL long_release: got n=%0d t=%0d short=%0d, expected n=1 t=%0d short=0",
                              cnt[IR] - b[IR], last[IR], cnt[IS] - b[IS], c1 + 80);
        end
    endtask

    task automatic test_long_boundary();
        int b[6];
        int c1;
        b = cnt; c1 = cyc + 1;
        hold(1'b1, 40); hold(1'b0, 40);
        n_vec++;
        if (cnt[IL] - b[IL] !== 0) begin
            n_err++; $display("FAIL lb_fall_wins: got %0d long pulses, expected 0", cnt[IL] - b[IL]);
        end
        n_vec++;
        if (cnt[IS] - b[IS] !== 1 || last[IS] !== c1 + 60) begin
            n_err++; $display("FAIL lb_short: got n=%0d t=%0d, expected n=1 t=%0d",
                              cnt[IS] - b[IS], last[IS], c1 + 60);
        end
        b = cnt; c1 = cyc + 1;
        hold(1'b1, 41); hold(1'b0, 40);
        n_vec++;
        if (cnt[IL] - b[IL] !== 1 || last[IL] !== c1 + 40 || last[IR] !== c1 + 41) begin
            n_err++; $display("FAIL lb_just_long: got n=%0d t=%0d rel=%0d, expected n=1 t=%0d rel=%0d",
                              cnt[IL] - b[IL], last[IL], last[IR], c1 + 40, c1 + 41);
        end
    endtask

    task automatic test_dbl_boundary();
        int b[6];
        int c1;
        b = cnt; c1 = cyc + 1;
        hold(1'b1, 8); hold(1'b0, 20); hold(1'b1, 5); hold(1'b0, 40);
        n_vec++;
        if (cnt[ID] - b[ID] !== 1 || last[ID] !== c1 + 28) begin
            n_err++; $display("FAIL db_rise_wins: got n=%0d t=%0d, expected n=1 t=%0d",
                              cnt[ID] - b[ID], last[ID], c1 + 28);
        end
        n_vec++;
        if (cnt[IS] - b[IS] !== 0) begin
            n_err++; $display("FAIL db_no_short: got %0d, expected 0", cnt[IS] - b[IS]);
        end
        b = cnt; c1 = cyc + 1;
        hold(1'b1, 8); hold(1'b0, 21); hold(1'b1, 5); hold(1'b0, 40);
        n_vec++;
        if (cnt[IS] - b[IS] !== 2 || cnt[ID] - b[ID] !== 0 || last[IP] !== c1 + 29) begin
            n_err++; $display("FAIL db_late: got short=%0d dbl=%0d press_t=%0d, expected 2/0/%0d",
                              cnt[IS] - b[IS], cnt[ID] - b[ID], last[IP], c1 + 29);
        end
    endtask

    task automatic test_enable();
        int b[6];
        int c1;
        b = cnt;
        bus.ButtonEvent_Enable = 1'b0;
        hold(1'b1, 10);
        n_vec++;
        if (cnt[IP] - b[IP] !== 0) begin
            n_err++; $display("FAIL en_off_press: got %0d, expected 0", cnt[IP] - b[IP]);
        end
        bus.ButtonEvent_Enable = 1'b1;
        hold(1'b1, 10); hold(1'b0, 10);
        n_vec++;
        if (cnt[IP] - b[IP] !== 0 || cnt[IR] - b[IR] !== 0) begin
            n_err++; $display("FAIL en_held_rise: got press=%0d rel=%0d, expected 0/0",
                              cnt[IP] - b[IP], cnt[IR] - b[IR]);
        end
        c1 = cyc + 1;
        hold(1'b1, 2); hold(1'b0, 40);
        n_vec++;
        if (cnt[IP] - b[IP] !== 1 || last[IP] !== c1 || cnt[IS] - b[IS] !== 1) begin
            n_err++; $display("FAIL en_fresh_press: got n=%0d t=%0d short=%0d, expected 1/%0d/1",
                              cnt[IP] - b[IP], last[IP], cnt[IS] - b[IS], c1);
        end
    endtask

    task automatic test_reset_mid_long();
        int b[6];
        int c1;
        b = cnt;
        hold(1'b1, 50);
        n_vec++;
        if (bus.ButtonEvent_Held !== 1'b1) begin
            n_err++; $display("FAIL rml_held: got %b, expected 1", bus.ButtonEvent_Held);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({pulses, bus.ButtonEvent_Held} !== 7'd0) begin
            n_err++; $display("FAIL rml_async_clear: got %b, expected 0", {pulses, bus.ButtonEvent_Held});
        end
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 20);
        n_vec++;
        if (cnt[IP] - b[IP] !== 1 || cnt[IRP] - b[IRP] !== 0 || bus.ButtonEvent_Held !== 1'b0) begin
            n_err++; $display("FAIL rml_after_reset: got press=%0d rep=%0d held=%b, expected 1/0/0",
                              cnt[IP] - b[IP], cnt[IRP] - b[IRP], bus.ButtonEvent_Held);
        end
        hold(1'b0, 5);
        n_vec++;
        if (cnt[IR] - b[IR] !== 0) begin
            n_err++; $display("FAIL rml_idle_fall: got %0d, expected 0", cnt[IR] - b[IR]);
        end
        c1 = cyc + 1;
        hold(1'b1, 3); hold(1'b0, 40);
        n_vec++;
        if (cnt[IP] - b[IP] !== 2 || last[IP] !== c1) begin
            n_err++; $display("FAIL rml_new_press: got n=%0d t=%0d, expected 2/%0d",
                              cnt[IP] - b[IP], last[IP], c1);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long();
        test_long_boundary();
        test_dbl_boundary();
        test_enable();
        test_reset_mid_long();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
